// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that shares one start/done sequential multiplier among NUM_REQ requesters.
// Optional WAIT-state watchdog is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_share_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 done_q;
  logic                 completion;
  logic [NUM_REQ-1:0]   ack_d;
  logic                 valid_d;
  logic [ID_W-1:0]      rsp_id_d;
  logic [2*WIDTH-1:0]   prod_d;
  logic                 busy_d;
  logic                 start_d;
  logic [WIDTH-1:0]     a_d, b_d;
  logic [WIDTH-1:0]     op_a [NUM_REQ];
  logic [WIDTH-1:0]     op_b [NUM_REQ];

  if (NUM_REQ < 2 || NUM_REQ > 16 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mult_share_arbiter: parameter out of range");
  end

  // Unpack the flat operand buses so the winner can be indexed directly.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a[i*WIDTH +: WIDTH];
    assign op_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  // A done level left over from the previous job must not count as completion.
  assign completion = mul_done & ~done_q;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  logic             err_d;

  assign tmo_hit = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // First pending request at or after rr_q, wrapping past NUM_REQ-1.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_d     = rr_q;
    ack_d    = '0;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    rsp_id_d = rsp_id;
    prod_d   = rsp_product;
    a_d      = mul_a;
    b_d      = mul_b;
`ifdef MULT_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ISSUE;
          id_d    = win;
          rr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          a_d     = op_a[win];
          b_d     = op_b[win];
          ack_d   = NUM_REQ'(1) << win;
          start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (completion) begin
          state_d  = S_RESP;
          valid_d  = 1'b1;
          rsp_id_d = id_q;
          prod_d   = mul_product;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d  = S_RESP;
          valid_d  = 1'b1;
          rsp_id_d = id_q;
          prod_d   = '0;
          err_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      rr_q        <= '0;
      done_q      <= 1'b0;
      ack         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rr_q        <= rr_d;
      done_q      <= mul_done;
      ack         <= ack_d;
      rsp_valid   <= valid_d;
      rsp_id      <= rsp_id_d;
      rsp_product <= prod_d;
      busy        <= busy_d;
      mul_start   <= start_d;
      mul_a       <= a_d;
      mul_b       <= b_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      rsp_err <= err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed steps plus randomized jobs
// against a queue-free arbitration/product reference and a behavioural multiplier.
module tb_mult_share_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned TMO = 16;
  localparam int unsigned IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     ack;
  logic             rsp_valid;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_product;
  logic             rsp_err;
  logic             busy;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_done = 1'b0;
  logic [2*W-1:0]   mul_product = '0;

  mult_share_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int op_a [N];
  int op_b [N];
  int ref_ptr = 0;
  int cyc = 0;
  int n_start = 0;
  int last_lat = 0;

  always @(posedge clk) begin
    cyc++;
    if (mul_start) n_start++;
  end

  // Behavioural multiplier: lat_cfg 0 = random latency, >0 fixed, <0 never completes.
  // stick > 0 keeps a leftover done level high for that many cycles after start.
  int lat_cfg = 0;
  int stick = 0;
  int high_cnt = 0;
  int run_cnt = 0;
  logic [W-1:0] ma, mb;

  always @(negedge clk) begin
    if (rst) begin
      mul_done = 1'b0;
      high_cnt = 0;
      run_cnt  = 0;
    end else if (mul_start) begin
      ma = mul_a;
      mb = mul_b;
      run_cnt = (lat_cfg < 0) ? 0 : ((lat_cfg == 0) ? int'($urandom_range(1, 8)) : lat_cfg);
      if (stick > 0 && mul_done) high_cnt = stick;
      else mul_done = 1'b0;
    end else if (high_cnt > 0) begin
      high_cnt--;
      if (high_cnt == 0) mul_done = 1'b0;
    end else if (run_cnt > 0) begin
      run_cnt--;
      if (run_cnt == 0) begin
        mul_done    = 1'b1;
        mul_product = {8'b0, ma} * {8'b0, mb};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({ack, rsp_valid, rsp_id, rsp_product, rsp_err, busy, mul_start});
  endfunction

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i][W-1:0];
      req_b[i*W +: W] = op_b[i][W-1:0];
    end
  endtask

  // Wait for the grant to exp, then for its response; returns at the response negedge.
  task automatic serve(input string tag, input int exp, input int exp_prod, input bit exp_err);
    int s0;
    int t_ack;
    bit got;
    s0  = n_start;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    chk({tag, "_ack"}, 32'(ack), 32'(1) << exp);
    chk({tag, "_start"}, 32'(mul_start), 32'd1);
    chk({tag, "_ops"}, 32'({mul_a, mul_b}), 32'({op_a[exp][W-1:0], op_b[exp][W-1:0]}));
    t_ack = cyc;
    @(negedge clk);
    chk({tag, "_ack_1cyc"}, 32'(ack), 32'd0);
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(exp));
    chk({tag, "_prod"}, 32'(rsp_product), 32'(exp_prod));
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, "_nstart"}, 32'(n_start - s0), 32'd1);
    last_lat = cyc - t_ack;
    ref_ptr  = (exp + 1) % N;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  initial begin
    int w;
    int s0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 0;
      op_b[i] = 0;
    end

    // Reset state, then idle with no requests.
    #40;
    chk("reset_outs", outs(), 32'd0);
    chk("reset_ops", 32'({mul_a, mul_b}), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_outs", outs(), 32'd0);
    chk("idle_no_start", 32'(n_start), 32'd0);

    // Single requester, fixed latency 4: response 5 cycles after the grant.
    lat_cfg = 4;
    op_a[0] = 12; op_b[0] = 13;
    drive_ops();
    req = 4'b0001;
    serve("single", 0, 156, 1'b0);
    chk("single_lat", 32'(last_lat), 32'd5);
    req = 4'b0000;
    lat_cfg = 0;

    // All four held: strict rotation 0,1,2,3,0.
    do_reset();
    op_a[0] = 3;  op_b[0] = 5;
    op_a[1] = 7;  op_b[1] = 11;
    op_a[2] = 13; op_b[2] = 17;
    op_a[3] = 19; op_b[3] = 23;
    drive_ops();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) serve("rr", j % N, op_a[j % N] * op_b[j % N], 1'b0);

    // Randomized request patterns against the round-robin reference.
    for (int j = 0; j < 24; j++) begin
      w = pick(req, ref_ptr);
      serve("rand", w, op_a[w] * op_b[w], 1'b0);
      req[w] = 1'($urandom_range(0, 1));
      op_a[w] = $urandom_range(0, 255);
      op_b[w] = $urandom_range(0, 255);
      for (int i = 0; i < N; i++) begin
        if (i != w && !req[i] && $urandom_range(0, 1) == 1) begin
          op_a[i] = $urandom_range(0, 255);
          op_b[i] = $urandom_range(0, 255);
          req[i]  = 1'b1;
        end
      end
      if (req == '0) req[$urandom_range(0, N-1)] = 1'b1;
      drive_ops();
    end

    // Done still high from the previous job: only a fresh rising edge completes.
    stick = 6;
    lat_cfg = 3;
    op_a[2] = 200; op_b[2] = 201;
    drive_ops();
    req = 4'b0100;
    serve("stuck", 2, 40200, 1'b0);
    chk("stuck_lat", 32'(last_lat), 32'd10);
    req = 4'b0000;
    stick = 0;

    // Async reset in WAIT abandons the job and resets the rotation pointer.
    lat_cfg = 30;
    op_a[0] = 21; op_b[0] = 2;
    op_a[3] = 33; op_b[3] = 3;
    drive_ops();
    req = 4'b0001;
    for (int t = 0; t < 50 && ack == '0; t++) @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    s0 = n_start;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 32'd0);
    chk("async_rst_ops", 32'({mul_a, mul_b}), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_no_restart", 32'(n_start - s0), 32'd0);
    rst = 1'b0;
    ref_ptr = 0;
    lat_cfg = 0;
    req = 4'b1001;
    serve("post_rst", 0, 42, 1'b0);
    req = 4'b0000;

`ifdef MULT_ARB_TIMEOUT_EN
    // Multiplier never completes: watchdog response after TMO WAIT cycles.
    lat_cfg = -1;
    op_a[1] = 9; op_b[1] = 9;
    drive_ops();
    req = 4'b0010;
    serve("tmo", 1, 0, 1'b1);
    chk("tmo_lat", 32'(last_lat), 32'(TMO + 1));
    lat_cfg = 0;
    op_a[1] = 255; op_b[1] = 255;
    drive_ops();
    serve("tmo_after", 1, 65025, 1'b0);
    req = 4'b0000;
`endif

    repeat (5) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
